mux_n_1_pipe: RTL and testbench

MUX_N_1_PIPE -- requirements
Module: mux_n_1_pipe

---
 rtl/mux_n_1_pipe.sv | 109 ++++++++++
 tb/tb_mux_n_1_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_1_pipe.sv
// N:1 data multiplexer with a single registered output stage supporting stall and flush.
// Define MUX_SEL_ERR_EN to build in the out-of-range select monitor (sticky flag + saturating count).
module mux_n_1_pipe #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned N_IN    = 4,
  parameter int unsigned NB_SEL  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_IN*NB_DATA-1:0] data_i,
  input  logic [NB_SEL-1:0]       sel_i,
  input  logic                    valid_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output logic [NB_DATA-1:0]      data_o,
  output logic                    valid_o,
  output logic                    sel_err_o,
  output logic [7:0]              err_cnt_o
);

  localparam int unsigned NB_CNT = 8;

  logic [NB_DATA-1:0] ops [N_IN];
  logic [NB_DATA-1:0] pick_c;
  logic               accept_c;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               valid_q, valid_d;

  for (genvar k = 0; k < N_IN; k++) begin : g_ops
    assign ops[k] = data_i[k*NB_DATA +: NB_DATA];
  end

  // Unmatched select values fall through to operand 0.
  always_comb begin
    pick_c = ops[0];
    for (int unsigned k = 1; k < N_IN; k++) begin
      if (sel_i == NB_SEL'(k)) pick_c = ops[k];
    end
  end

  assign accept_c = valid_i & ~stall_i & ~flush_i;

  // Flush beats stall beats load.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush_i) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      valid_d = valid_i;
      if (valid_i) data_d = pick_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

`ifdef MUX_SEL_ERR_EN
  logic              sel_oor_c;
  logic              err_q, err_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  // With a fully populated select space no value can be out of range.
  if (N_IN < (1 << NB_SEL)) begin : g_oor
    assign sel_oor_c = (sel_i >= NB_SEL'(N_IN));
  end else begin : g_full
    assign sel_oor_c = 1'b0;
  end

  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (accept_c && sel_oor_c) begin
      err_d = 1'b1;
      if (cnt_q != {NB_CNT{1'b1}}) cnt_d = cnt_q + NB_CNT'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign sel_err_o = err_q;
  assign err_cnt_o = cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept_c;
  assign sel_err_o     = 1'b0;
  assign err_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Scoreboard bench: two instances (N_IN=4 full select space, N_IN=3 with an out-of-range code)
// share stimulus; a behavioural model predicts every cycle's outputs and a monitor compares.
module tb_mux_n_1_pipe;

`ifdef MUX_SEL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic        v;
    logic        e;
    logic [7:0]  c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] data_i = '0;
  logic [1:0]   sel_i = '0;
  logic         valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic [31:0]  d4, d3;
  logic         v4, v3, e4, e3;
  logic [7:0]   c4, c3;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;

  exp_t m4 = '{d: '0, v: 1'b0, e: 1'b0, c: '0};
  exp_t m3 = '{d: '0, v: 1'b0, e: 1'b0, c: '0};
  exp_t q4[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  mux_n_1_pipe #(.NB_DATA(32), .N_IN(4), .NB_SEL(2)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .sel_i(sel_i), .valid_i(valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .data_o(d4), .valid_o(v4),
    .sel_err_o(e4), .err_cnt_o(c4));

  mux_n_1_pipe #(.NB_DATA(32), .N_IN(3), .NB_SEL(2)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i[95:0]), .sel_i(sel_i), .valid_i(valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .data_o(d3), .valid_o(v3),
    .sel_err_o(e3), .err_cnt_o(c3));

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference behaviour of one mux with n operands.
  function automatic exp_t nxt(exp_t s, int n);
    exp_t r = s;
    int   s_idx = int'(sel_i);
    int   idx = (s_idx < n) ? s_idx : 0;
    if (flush_i) begin
      r.d = '0;
      r.v = 1'b0;
    end else if (!stall_i) begin
      r.v = valid_i;
      if (valid_i) begin
        r.d = data_i[idx*32 +: 32];
        if (ERR_EN && s_idx >= n) begin
          r.e = 1'b1;
          if (r.c != 8'd255) r.c = r.c + 8'd1;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 = '{d: '0, v: 1'b0, e: 1'b0, c: '0};
      m3 = '{d: '0, v: 1'b0, e: 1'b0, c: '0};
      q4.delete();
      q3.delete();
      pushed = popped;
    end else begin
      m4 = nxt(m4, 4);
      m3 = nxt(m3, 3);
      q4.push_back(m4);
      q3.push_back(m3);
      pushed++;
    end
  end

  // Monitor: compare every presented cycle against the predicted state.
  always @(negedge clk) begin
    if (rst_n && q4.size() > 0 && q3.size() > 0) begin
      exp_t x4, x3;
      x4 = q4.pop_front();
      x3 = q3.pop_front();
      popped++;
      chk("sb4_data", d4, x4.d);
      chk("sb4_valid", 32'(v4), 32'(x4.v));
      chk("sb4_err", 32'(e4), 32'(x4.e));
      chk("sb4_cnt", 32'(c4), 32'(x4.c));
      chk("sb3_data", d3, x3.d);
      chk("sb3_valid", 32'(v3), 32'(x3.v));
      chk("sb3_err", 32'(e3), 32'(x3.e));
      chk("sb3_cnt", 32'(c3), 32'(x3.c));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_d4"}, d4, 32'h0);
    chk({nm, "_v4"}, 32'(v4), 32'h0);
    chk({nm, "_e4"}, 32'(e4), 32'h0);
    chk({nm, "_c4"}, 32'(c4), 32'h0);
    chk({nm, "_d3"}, d3, 32'h0);
    chk({nm, "_v3"}, 32'(v3), 32'h0);
    chk({nm, "_e3"}, 32'(e3), 32'h0);
    chk({nm, "_c3"}, 32'(c3), 32'h0);
  endtask

  logic [31:0] ops [4];

  initial begin
    ops[0] = 32'h11111111; ops[1] = 32'h22222222;
    ops[2] = 32'h33333333; ops[3] = 32'h44444444;
    data_i = {ops[3], ops[2], ops[1], ops[0]};

    cyc(); cyc();
    chk_zero("reset");
    rst_n = 1'b1;

    // Full-rate back-to-back loads.
    valid_i = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel_i = 2'(s);
      cyc();
      chk("burst_data", d4, ops[s]);
      chk("burst_valid", 32'(v4), 32'h1);
    end

    // Long stall holds data while select changes underneath.
    sel_i = 2'd2;
    cyc();
    chk("pre_stall", d4, 32'h33333333);
    stall_i = 1'b1;
    sel_i   = 2'd1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_hold", d4, 32'h33333333);
      chk("stall_valid", 32'(v4), 32'h1);
    end
    stall_i = 1'b0;
    cyc();
    chk("stall_release", d4, 32'h22222222);

    // Flush wins over stall.
    stall_i = 1'b1;
    flush_i = 1'b1;
    cyc();
    chk("flush_data", d4, 32'h0);
    chk("flush_valid", 32'(v4), 32'h0);
    stall_i = 1'b0;
    flush_i = 1'b0;

    // Out-of-range select on the 3-input instance.
    sel_i = 2'd3;
    cyc();
    chk("oor_data3", d3, 32'h11111111);
    chk("oor_data4", d4, 32'h44444444);
    chk("oor_err3", 32'(e3), ERR_EN ? 32'h1 : 32'h0);
    chk("oor_cnt3", 32'(c3), ERR_EN ? 32'h1 : 32'h0);
    chk("oor_err4", 32'(e4), 32'h0);
    for (int i = 0; i < 299; i++) cyc();
    chk("oor_sat3", 32'(c3), ERR_EN ? 32'd255 : 32'h0);

    // Rejected out-of-range inputs must not count.
    stall_i = 1'b1;
    cyc();
    stall_i = 1'b0;
    valid_i = 1'b0;
    cyc();
    chk("oor_hold3", 32'(c3), ERR_EN ? 32'd255 : 32'h0);

    // Asynchronous reset between edges.
    valid_i = 1'b1;
    sel_i   = 2'd3;
    cyc();
    chk("prerst_valid", 32'(v3), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    cyc();
    rst_n = 1'b1;
    sel_i = 2'd1;
    cyc();
    chk("post_rst4", d4, 32'h22222222);
    chk("post_rst3", d3, 32'h22222222);

    // Randomised traffic checked through the scoreboard.
    for (int i = 0; i < 500; i++) begin
      data_i  = {$urandom, $urandom, $urandom, $urandom};
      sel_i   = 2'($urandom_range(0, 3));
      valid_i = ($urandom_range(0, 9) < 7);
      stall_i = ($urandom_range(0, 9) < 2);
      flush_i = ($urandom_range(0, 19) == 0);
      cyc();
    end
    valid_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(q4.size() + q3.size()), 32'h0);
    chk("sb_balance", 32'(pushed - popped), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
